// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch/data requesters, the arbiter and the shared memory port.
// The master modport is the arbiter side; slave is the requester/memory environment.
interface mem_port_arbiter_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        if_ready;
   logic [31:0] if_rdata;

   logic        dm_req;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_be;
   logic        dm_ready;
   logic [31:0] dm_rdata;

   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   modport master (
      input  if_req, if_addr, if_kill,
      output if_ready, if_rdata,
      input  dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      output dm_ready, dm_rdata,
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_ack, mem_rdata
   );

   modport slave (
      output if_req, if_addr, if_kill,
      input  if_ready, if_rdata,
      output dm_req, dm_we, dm_addr, dm_wdata, dm_be,
      input  dm_ready, dm_rdata,
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_ack, mem_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one shared memory port.
// Data wins by default; fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_port_arbiter #(
   parameter int unsigned STARVE_MAX = 4
) (
   input logic            clk,
   input logic            rst,
   mem_port_arbiter_if.master bus
);
   localparam int unsigned SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t        state_q;
   state_t        state_d;
   logic [SW-1:0] starve_q;
   logic          kill_q;
   logic          grant_i_c;
   logic          grant_d_c;
   logic          done_i_c;
   logic          done_d_c;

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Grant decisions only in IDLE, so an ack cycle can never overlap a new grant.
   always_comb begin
      state_d   = state_q;
      grant_i_c = 1'b0;
      grant_d_c = 1'b0;
      done_i_c  = 1'b0;
      done_d_c  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.dm_req && (starve_q < STARVE_LIM)) begin
               state_d   = BUSY_D;
               grant_d_c = 1'b1;
            end else if (bus.if_req && !bus.if_kill) begin
               state_d   = BUSY_I;
               grant_i_c = 1'b1;
            end
         end
         BUSY_I: begin
            if (bus.mem_ack) begin
               state_d  = IDLE;
               done_i_c = 1'b1;
            end
         end
         BUSY_D: begin
            if (bus.mem_ack) begin
               state_d  = IDLE;
               done_d_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command capture, completion and read-data return.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.mem_be    <= '0;
         bus.if_ready  <= 1'b0;
         bus.if_rdata  <= '0;
         bus.dm_ready  <= 1'b0;
         bus.dm_rdata  <= '0;
         starve_q      <= '0;
         kill_q        <= 1'b0;
      end else begin
         bus.if_ready <= 1'b0;
         bus.dm_ready <= 1'b0;

         if (grant_d_c) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= bus.dm_we;
            bus.mem_addr  <= bus.dm_addr;
            bus.mem_wdata <= bus.dm_wdata;
            bus.mem_be    <= bus.dm_be;
         end else if (grant_i_c) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= bus.if_addr;
            bus.mem_wdata <= '0;
            bus.mem_be    <= 4'b1111;
         end

         if (done_i_c) begin
            bus.mem_req <= 1'b0;
            kill_q      <= 1'b0;
            if (!kill_q && !bus.if_kill) begin
               bus.if_ready <= 1'b1;
               bus.if_rdata <= bus.mem_rdata;
            end
         end else if ((state_q == BUSY_I) && bus.if_kill) begin
            kill_q <= 1'b1;
         end

         if (done_d_c) begin
            bus.mem_req  <= 1'b0;
            bus.dm_ready <= 1'b1;
            if (!bus.mem_we) bus.dm_rdata <= bus.mem_rdata;
         end

         // Starvation count only grows while fetch is actually waiting.
         if (grant_i_c || ((state_q == IDLE) && !bus.if_req)) begin
            starve_q <= '0;
         end else if (grant_d_c && bus.if_req && (starve_q < STARVE_LIM)) begin
            starve_q <= starve_q + SW'(1);
         end
      end
   end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus directed corner sequences,
// with a scoreboard of expected memory commands and ready responses.
module tb_mem_port_arbiter;
   logic clk;
   logic rst;

   mem_port_arbiter_if bus();

   mem_port_arbiter #(.STARVE_MAX(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
   } cmd_t;

   typedef struct {
      logic        side;
      logic [31:0] rdata;
   } rsp_t;

   typedef struct {
      logic        side;
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  be;
      int          delay;
      logic        exp_we;
      logic [31:0] exp_wdata;
      logic [3:0]  exp_be;
      logic [31:0] exp_rdata;
      int          exp_lat;
   } vec_t;

   localparam int NV = 6;
   vec_t vecs [NV];

   cmd_t exp_cmd_q [$];
   rsp_t exp_rsp_q [$];

   int n_checks = 0;
   int n_fail   = 0;

   int ack_delay = 0;
   bit auto_ack  = 1'b1;
   int man_req   = 0;
   int man_done  = 0;
   int n_acks    = 0;

   function automatic logic [31:0] mem_model(input logic [31:0] addr);
      if (addr == 32'h0000_0100) return 32'h0000_0013;
      return addr ^ 32'hC0DE_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push_cmd(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] be);
      cmd_t c;
      c.we = we; c.addr = addr; c.wdata = wdata; c.be = be;
      exp_cmd_q.push_back(c);
   endtask

   task automatic push_rsp(input logic side, input logic [31:0] rdata);
      rsp_t r;
      r.side = side; r.rdata = rdata;
      exp_rsp_q.push_back(r);
   endtask

   // Memory responder: acks after ack_delay extra cycles, or on a manual request.
   initial begin
      int cnt = 0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            bus.mem_ack = 1'b0;
            cnt = 0;
         end else if (bus.mem_ack) begin
            bus.mem_ack = 1'b0;
            cnt = 0;
         end else if (man_req > man_done) begin
            man_done++;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hBAD0_BAD0;
            n_acks++;
         end else if (auto_ack && bus.mem_req) begin
            if (cnt >= ack_delay) begin
               bus.mem_ack   = 1'b1;
               bus.mem_rdata = mem_model(bus.mem_addr);
               n_acks++;
               cnt = 0;
            end else begin
               cnt++;
            end
         end
      end
   end

   // Monitor: checks each new command, its stability, and every ready pulse against the queues.
   initial begin
      logic prev_req = 1'b0;
      cmd_t cur;
      rsp_t r;
      cur.we = 1'b0; cur.addr = '0; cur.wdata = '0; cur.be = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req = 1'b0;
         end else begin
            if (bus.mem_req && !prev_req) begin
               if (exp_cmd_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_grant: mem_req rose with addr 0x%08h, none queued", bus.mem_addr);
               end else begin
                  cur = exp_cmd_q.pop_front();
               end
            end
            if (bus.mem_req) begin
               check("mem_we",    32'(bus.mem_we), 32'(cur.we));
               check("mem_addr",  bus.mem_addr,    cur.addr);
               check("mem_wdata", bus.mem_wdata,   cur.wdata);
               check("mem_be",    32'(bus.mem_be), 32'(cur.be));
            end
            if (bus.if_ready || bus.dm_ready) begin
               if (exp_rsp_q.size() == 0) begin
                  n_checks++;
                  n_fail++;
                  $display("FAIL unexpected_ready: if_ready=%0b dm_ready=%0b, none queued",
                           bus.if_ready, bus.dm_ready);
               end else begin
                  r = exp_rsp_q.pop_front();
                  check("ready_side", 32'(bus.dm_ready), 32'(r.side));
                  if (bus.dm_ready) check("dm_rdata", bus.dm_rdata, r.rdata);
                  else              check("if_rdata", bus.if_rdata, r.rdata);
               end
            end
            prev_req = bus.mem_req;
         end
      end
   end

   task automatic wait_side(input bit side, input int start_lat, input int exp_lat, input string name);
      int lat = start_lat;
      bit seen = 1'b0;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         lat++;
         if ((side && bus.dm_ready) || (!side && bus.if_ready)) begin
            seen = 1'b1;
            break;
         end
      end
      if (side) bus.dm_req = 1'b0;
      else      bus.if_req = 1'b0;
      if (!seen) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s_timeout: no ready within 60 cycles", name);
      end else begin
         check({name, "_latency"}, 32'(lat), 32'(exp_lat));
      end
   endtask

   task automatic apply_vec(input vec_t v, input string name);
      ack_delay     = v.delay;
      bus.dm_we     = v.we;
      bus.dm_wdata  = v.wdata;
      bus.dm_be     = v.be;
      if (v.side) begin
         bus.dm_addr = v.addr;
         bus.dm_req  = 1'b1;
      end else begin
         bus.if_addr = v.addr;
         bus.if_req  = 1'b1;
      end
      push_cmd(v.exp_we, v.addr, v.exp_wdata, v.exp_be);
      push_rsp(v.side, v.exp_rdata);
      wait_side(v.side, 1, v.exp_lat, name);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: bench did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int acks0;
      int dm_cnt;
      int if_at;
      bit if_seen;

      //            side we    addr          wdata         be       dly exp_we exp_wdata     exp_be   exp_rdata     lat
      vecs[0] = '{1'b0, 1'b1, 32'h0000_0100, 32'h1234_5678, 4'b0010, 0, 1'b0, 32'h0,        4'b1111, 32'h0000_0013, 3};
      vecs[1] = '{1'b1, 1'b0, 32'h0000_0200, 32'h5555_5555, 4'b1111, 0, 1'b0, 32'h5555_5555, 4'b1111, 32'hC0DE_0200, 3};
      vecs[2] = '{1'b1, 1'b1, 32'h0000_0204, 32'hDEAD_BEEF, 4'b0011, 5, 1'b1, 32'hDEAD_BEEF, 4'b0011, 32'hC0DE_0200, 8};
      vecs[3] = '{1'b0, 1'b0, 32'h0000_0104, 32'h0,        4'b0000, 2, 1'b0, 32'h0,        4'b1111, 32'hC0DE_0104, 5};
      vecs[4] = '{1'b1, 1'b0, 32'h0000_0300, 32'hAAAA_0000, 4'b0100, 1, 1'b0, 32'hAAAA_0000, 4'b0100, 32'hC0DE_0300, 4};
      vecs[5] = '{1'b1, 1'b1, 32'h0000_0308, 32'h0BAD_F00D, 4'b1000, 0, 1'b1, 32'h0BAD_F00D, 4'b1000, 32'hC0DE_0300, 3};

      rst = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = '0; bus.if_kill = 1'b0;
      bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0; bus.dm_be = '0;
      repeat (3) @(negedge clk);

      check("rst_mem_req",   32'(bus.mem_req),  0);
      check("rst_if_ready",  32'(bus.if_ready), 0);
      check("rst_dm_ready",  32'(bus.dm_ready), 0);
      check("rst_if_rdata",  bus.if_rdata,      0);
      check("rst_dm_rdata",  bus.dm_rdata,      0);
      check("rst_mem_addr",  bus.mem_addr,      0);
      check("rst_mem_wdata", bus.mem_wdata,     0);
      check("rst_mem_be",    32'(bus.mem_be),   0);
      check("rst_state",     32'(dut.state_q),  0);
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < NV; i++) begin
         apply_vec(vecs[i], $sformatf("vec%0d", i));
         @(negedge clk);
      end
      check("hold_if_rdata", bus.if_rdata, 32'hC0DE_0104);

      // Simultaneous fetch and load: data first, then fetch.
      ack_delay = 0;
      bus.if_addr = 32'h0000_0180; bus.if_req = 1'b1;
      bus.dm_addr = 32'h0000_0200; bus.dm_we = 1'b0; bus.dm_be = 4'b1111; bus.dm_wdata = '0;
      bus.dm_req = 1'b1;
      push_cmd(1'b0, 32'h0000_0200, 32'h0, 4'b1111);
      push_cmd(1'b0, 32'h0000_0180, 32'h0, 4'b1111);
      push_rsp(1'b1, 32'hC0DE_0200);
      push_rsp(1'b0, 32'hC0DE_0180);
      dm_cnt = 0; if_seen = 1'b0;
      for (int c = 0; c < 40 && !if_seen; c++) begin
         @(negedge clk);
         if (bus.dm_ready) begin dm_cnt++; bus.dm_req = 1'b0; end
         if (bus.if_ready) begin if_seen = 1'b1; bus.if_req = 1'b0; end
      end
      check("simul_fetch_done", 32'(if_seen), 1);
      check("simul_dm_before_if", 32'(dm_cnt), 1);
      @(negedge clk);

      // Starvation: continuous data requests, fetch forced through after 4 data grants.
      bus.if_addr = 32'h0000_0500; bus.if_req = 1'b1;
      bus.dm_addr = 32'h0000_0400; bus.dm_we = 1'b0; bus.dm_be = 4'b1111; bus.dm_wdata = 32'h0000_0077;
      bus.dm_req = 1'b1;
      for (int k = 0; k < 4; k++) begin
         push_cmd(1'b0, 32'h0000_0400, 32'h0000_0077, 4'b1111);
         push_rsp(1'b1, 32'hC0DE_0400);
      end
      push_cmd(1'b0, 32'h0000_0500, 32'h0, 4'b1111);
      push_rsp(1'b0, 32'hC0DE_0500);
      push_cmd(1'b0, 32'h0000_0400, 32'h0000_0077, 4'b1111);
      push_rsp(1'b1, 32'hC0DE_0400);
      dm_cnt = 0; if_at = -1;
      for (int c = 0; c < 80 && dm_cnt < 5; c++) begin
         @(negedge clk);
         if (bus.if_ready) begin if_at = dm_cnt; bus.if_req = 1'b0; end
         if (bus.dm_ready) begin
            dm_cnt++;
            if (dm_cnt == 5) bus.dm_req = 1'b0;
         end
      end
      check("starve_data_grants", 32'(dm_cnt), 5);
      check("starve_fetch_slot",  32'(if_at),  4);
      @(negedge clk);

      // Kill while fetch in flight: ack consumed, no if_ready.
      ack_delay = 3;
      acks0 = n_acks;
      bus.if_addr = 32'h0000_0600; bus.if_req = 1'b1;
      push_cmd(1'b0, 32'h0000_0600, 32'h0, 4'b1111);
      for (int c = 0; c < 10 && !bus.mem_req; c++) @(negedge clk);
      check("kill_busy_reached", 32'(bus.mem_req), 1);
      bus.if_kill = 1'b1; bus.if_req = 1'b0;
      @(negedge clk);
      bus.if_kill = 1'b0;
      repeat (8) @(negedge clk);
      check("kill_ack_consumed", 32'(n_acks - acks0), 1);
      check("kill_mem_req_low",  32'(bus.mem_req),    0);
      check("kill_state_idle",   32'(dut.state_q),    0);
      check("kill_if_rdata_hold", bus.if_rdata,       32'hC0DE_0500);

      // Kill in IDLE blocks the fetch grant for that cycle.
      ack_delay = 0;
      bus.if_addr = 32'h0000_0640; bus.if_req = 1'b1; bus.if_kill = 1'b1;
      @(negedge clk);
      check("kill_idle_no_grant", 32'(bus.mem_req), 0);
      bus.if_kill = 1'b0;
      push_cmd(1'b0, 32'h0000_0640, 32'h0, 4'b1111);
      push_rsp(1'b0, 32'hC0DE_0640);
      wait_side(1'b0, 1, 3, "kill_release");
      @(negedge clk);

      // Kill has no effect on a data access.
      ack_delay = 2;
      bus.dm_addr = 32'h0000_0700; bus.dm_we = 1'b0; bus.dm_be = 4'b1111; bus.dm_wdata = '0;
      bus.dm_req = 1'b1;
      push_cmd(1'b0, 32'h0000_0700, 32'h0, 4'b1111);
      push_rsp(1'b1, 32'hC0DE_0700);
      @(negedge clk);
      bus.if_kill = 1'b1;
      @(negedge clk);
      bus.if_kill = 1'b0;
      wait_side(1'b1, 3, 5, "kill_dm");
      @(negedge clk);

      // Reset mid-BUSY_D, then a stray ack.
      auto_ack = 1'b0;
      acks0 = n_acks;
      bus.dm_addr = 32'h0000_0800; bus.dm_we = 1'b0; bus.dm_be = 4'b1111; bus.dm_wdata = 32'h0000_0011;
      bus.dm_req = 1'b1;
      push_cmd(1'b0, 32'h0000_0800, 32'h0000_0011, 4'b1111);
      for (int c = 0; c < 10 && !bus.mem_req; c++) @(negedge clk);
      check("rst_mid_busy_reached", 32'(bus.mem_req), 1);
      rst = 1'b1; bus.dm_req = 1'b0;
      @(negedge clk);
      check("rst_mid_mem_req",  32'(bus.mem_req),  0);
      check("rst_mid_dm_rdata", bus.dm_rdata,      0);
      check("rst_mid_mem_addr", bus.mem_addr,      0);
      rst = 1'b0;
      man_req++;
      repeat (4) @(negedge clk);
      check("rst_stray_ack_sent", 32'(n_acks - acks0), 1);
      check("rst_after_mem_req",  32'(bus.mem_req),    0);
      check("rst_after_state",    32'(dut.state_q),    0);
      check("rst_after_dm_rdata", bus.dm_rdata,        0);
      auto_ack = 1'b1;

      apply_vec(vecs[0], "post_rst_fetch");
      repeat (3) @(negedge clk);

      check("cmd_queue_empty", 32'(exp_cmd_q.size()), 0);
      check("rsp_queue_empty", 32'(exp_rsp_q.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
